// File: rtl/max_pooling.sv
// max_pooling: 2x2/stride-2 signed max-pool with argmax history, raster in and raster out
module max_pooling #(
   parameter int size = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_pool_start,
   input  logic               i_in_valid,
   input  logic signed [15:0] i_in_value,
   output logic               o_in_ready,
   output logic signed [15:0] o_pooled_value,
   output logic [2:0]         o_history_value,
   output logic               o_out_valid,
   output logic               o_pool_end
);
   localparam int CW = $clog2(2 * size);
   localparam int HW = (size > 1) ? $clog2(size) : 1;
   localparam logic [CW-1:0] LAST = CW'(2 * size - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             r_state, w_next;
   logic [CW-1:0]      r_row, r_col;
   logic signed [15:0] r_lat, r_pooled;
   logic [2:0]         r_hist;
   logic               r_out_valid, r_pool_end;
   logic [18:0]        r_rowbuf [size];
   logic               w_acc, w_last, w_new_win, w_bot_win;
   logic signed [15:0] w_max, w_rb_val;
   logic [1:0]         w_idx;
   logic [HW-1:0]      w_half;
   logic [18:0]        w_rb;
   assign w_acc     = (r_state == RUN) && i_pool_start && i_in_valid;
   assign w_last    = w_acc && (r_row == LAST) && (r_col == LAST);
   assign w_half    = HW'(r_col >> 1);
   assign w_rb      = r_rowbuf[w_half];
   assign w_rb_val  = w_rb[15:0];
   // the later pixel of a pair wins only when strictly greater, so ties keep the lower index
   assign w_new_win = i_in_value > r_lat;
   assign w_max     = w_new_win ? i_in_value : r_lat;
   assign w_idx     = {r_row[0], w_new_win};
   assign w_bot_win = w_max > w_rb_val;
   assign o_in_ready      = (r_state == RUN);
   assign o_pooled_value  = r_pooled;
   assign o_history_value = r_hist;
   assign o_out_valid     = r_out_valid;
   assign o_pool_end      = r_pool_end;
   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end
   // next state: dropping pool_start returns to IDLE from RUN (abort) or DONE
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE) ? (i_pool_start ? RUN : IDLE) :
               !i_pool_start     ? IDLE :
               w_last            ? DONE : r_state;
   end
   // row/col position of the next accepted pixel, held at zero outside an active frame
   always_ff @(posedge i_clk) begin
      if (i_reset || r_state != RUN || !i_pool_start) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_in_valid) begin
         r_col <= (r_col == LAST) ? '0 : r_col + 1'b1;
         if (r_col == LAST) r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
      end
   end
   // window datapath: latch left pixel, fold top pair into rowbuf, merge bottom pair on BR
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_lat       <= '0;
         r_pooled    <= '0;
         r_hist      <= '0;
         r_out_valid <= 1'b0;
         r_pool_end  <= 1'b0;
         for (int k = 0; k < size; k++) r_rowbuf[k] <= '0;
      end else begin
         r_out_valid <= w_acc && r_row[0] && r_col[0];
         r_pool_end  <= (w_next == DONE);
         if (w_acc) begin
            if (!r_col[0]) r_lat <= i_in_value;
            else if (!r_row[0]) r_rowbuf[w_half] <= {1'b0, w_idx, w_max};
            else begin
               r_pooled <= w_bot_win ? w_max : w_rb_val;
               r_hist   <= w_bot_win ? {1'b0, w_idx} : w_rb[18:16];
            end
         end
      end
   end
endmodule

// File: tb/tb_max_pooling.sv
// tb_max_pooling: table, directed and random frames checked against a window-max reference model
module tb_max_pooling;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   logic s2, v2, s8, v8;
   logic signed [15:0] x2, x8;
   logic r2, r8, ov2, ov8, pe2, pe8;
   logic signed [15:0] pv2, pv8;
   logic [2:0] hv2, hv8;
   bit big;
   logic w_ov, w_pe, w_rdy;
   logic signed [15:0] w_pv;
   logic [2:0] w_hv;
   assign w_ov  = big ? ov8 : ov2;
   assign w_pe  = big ? pe8 : pe2;
   assign w_rdy = big ? r8 : r2;
   assign w_pv  = big ? pv8 : pv2;
   assign w_hv  = big ? hv8 : hv2;

   max_pooling #(.size(2)) u2 (
      .i_clk(clk), .i_reset(rst), .i_pool_start(s2), .i_in_valid(v2), .i_in_value(x2),
      .o_in_ready(r2), .o_pooled_value(pv2), .o_history_value(hv2), .o_out_valid(ov2),
      .o_pool_end(pe2));
   max_pooling #(.size(8)) u8 (
      .i_clk(clk), .i_reset(rst), .i_pool_start(s8), .i_in_valid(v8), .i_in_value(x8),
      .o_in_ready(r8), .o_pooled_value(pv8), .o_history_value(hv8), .o_out_valid(ov8),
      .o_pool_end(pe8));

   int n_chk = 0, n_fail = 0;
   int frame[256];
   int ev[64];
   int eh[64];
   typedef struct {
      int px[16];
      int v[4];
      int h[4];
   } vec_t;
   vec_t tbl[3];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit s, input bit v, input int x);
      if (big) begin s8 = s; v8 = v; x8 = 16'(x); end
      else     begin s2 = s; v2 = v; x2 = 16'(x); end
   endtask

   // reference: max over TL,TR,BL,BR, replaced only by a strictly greater later pixel
   task automatic model(input int n);
      int sz, base, b, bi;
      int p[4];
      sz = n / 2;
      for (int i = 0; i < sz; i++)
         for (int j = 0; j < sz; j++) begin
            base = 2 * i * n + 2 * j;
            p = '{frame[base], frame[base + 1], frame[base + n], frame[base + n + 1]};
            b = p[0];
            bi = 0;
            for (int k = 1; k < 4; k++)
               if (p[k] > b) begin b = p[k]; bi = k; end
            ev[i * sz + j] = b;
            eh[i * sz + j] = bi;
         end
   endtask

   task automatic run_frame(input int n, input int gap, input string tag);
      int k;
      bit br;
      k = 0;
      drive(1, 1, 32767);
      @(negedge clk);
      chk({tag, " ready"}, w_rdy, 1);
      chk({tag, " idle pixel no strobe"}, w_ov, 0);
      for (int p = 0; p < n * n; p++) begin
         for (int g = 0; g < gap; g++) begin
            drive(1, 0, 0);
            @(negedge clk);
            chk({tag, " gap no strobe"}, w_ov, 0);
         end
         drive(1, 1, frame[p]);
         @(negedge clk);
         br = ((p / n) % 2 == 1) && ((p % n) % 2 == 1);
         chk({tag, " out_valid"}, w_ov, int'(br));
         if (br) begin
            chk({tag, " value"}, int'(w_pv), ev[k]);
            chk({tag, " history"}, int'(w_hv), eh[k]);
            k++;
         end
         chk({tag, " pool_end"}, w_pe, int'(p == n * n - 1));
      end
      drive(1, 1, 0);
      @(negedge clk);
      chk({tag, " done no strobe"}, w_ov, 0);
      chk({tag, " done not ready"}, w_rdy, 0);
      chk({tag, " pool_end sticky"}, w_pe, 1);
      drive(0, 0, 0);
      @(negedge clk);
      chk({tag, " pool_end clears"}, w_pe, 0);
      chk({tag, " idle not ready"}, w_rdy, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) tbl[0].px[i] = i;
      tbl[0].v = '{5, 7, 13, 15};
      tbl[0].h = '{3, 3, 3, 3};
      tbl[1].px = '{9, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 9};
      tbl[1].v = '{9, 9, 9, 9};
      tbl[1].h = '{0, 1, 2, 3};
      tbl[2].px = '{-5, -5, -1, -32768, -5, -5, -2, -3, 3, 7, 0, 0, 7, 7, 0, 0};
      tbl[2].v = '{-5, -1, 7, 0};
      tbl[2].h = '{0, 0, 1, 0};
      rst = 1'b1;
      s2 = 0; v2 = 0; x2 = 0; s8 = 0; v8 = 0; x8 = 0;
      repeat (2) @(negedge clk);
      chk("reset ov2", ov2, 0);   chk("reset pv2", int'(pv2), 0);
      chk("reset hv2", int'(hv2), 0); chk("reset pe2", pe2, 0);
      chk("reset rdy2", r2, 0);   chk("reset ov8", ov8, 0);
      chk("reset pv8", int'(pv8), 0); chk("reset hv8", int'(hv8), 0);
      chk("reset pe8", pe8, 0);   chk("reset rdy8", r8, 0);
      rst = 1'b0;
      big = 0;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 16; i++) frame[i] = tbl[t].px[i];
         for (int i = 0; i < 4; i++) begin ev[i] = tbl[t].v[i]; eh[i] = tbl[t].h[i]; end
         run_frame(4, 0, $sformatf("table%0d", t));
      end
      for (int i = 0; i < 16; i++) frame[i] = tbl[0].px[i];
      for (int i = 0; i < 4; i++) begin ev[i] = tbl[0].v[i]; eh[i] = tbl[0].h[i]; end
      run_frame(4, 2, "gaps");
      drive(1, 1, 99);
      @(negedge clk);
      for (int p = 0; p < 6; p++) begin
         drive(1, 1, p);
         @(negedge clk);
         chk("abort pre out_valid", w_ov, int'(p == 5));
         chk("abort pre pool_end", w_pe, 0);
      end
      drive(0, 1, 6);
      @(negedge clk);
      chk("abort no strobe", w_ov, 0);
      chk("abort no pool_end", w_pe, 0);
      chk("abort not ready", w_rdy, 0);
      drive(0, 0, 0);
      @(negedge clk);
      chk("abort idle no strobe", w_ov, 0);
      run_frame(4, 0, "restart");
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++)
            frame[i] = (r % 2 == 0) ? int'($urandom_range(6, 0)) - 3 : int'($signed(16'($urandom)));
         model(4);
         run_frame(4, r % 2, $sformatf("rnd2_%0d", r));
      end
      big = 1;
      drive(1, 1, 0);
      @(negedge clk);
      for (int p = 0; p < 20; p++) begin
         drive(1, 1, p);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midreset ov", w_ov, 0);
      chk("midreset value", int'(w_pv), 0);
      chk("midreset history", int'(w_hv), 0);
      chk("midreset pool_end", w_pe, 0);
      chk("midreset ready", w_rdy, 0);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) frame[i] = i;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            ev[i * 8 + j] = 32 * i + 2 * j + 17;
            eh[i * 8 + j] = 3;
         end
      run_frame(16, 0, "ramp8");
      for (int i = 0; i < 256; i++) frame[i] = int'($signed(16'($urandom)));
      model(16);
      run_frame(16, 1, "rnd8");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
